// File: rtl/wload_pkg.sv
// Shared types and default sizing for the systolic-array weight loader.
package wload_pkg;

  localparam int unsigned DEF_ARRAY_DIM = 4;
  localparam int unsigned DEF_W_W       = 8;
  localparam int unsigned DEF_PSUM_W    = 16;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_IDLE = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } wload_state_e;

  typedef logic [DEF_ARRAY_DIM-1:0][DEF_W_W-1:0] wload_row_t;

endpackage

// File: rtl/wload_row_buf.sv
// Staging register file: DEPTH rows of WIDTH bits, one write port, one indexed read.
module wload_row_buf
  import wload_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_ARRAY_DIM,
  parameter int unsigned WIDTH = DEF_ARRAY_DIM * DEF_W_W,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/weight_loader.sv
// Weight-load sequencer: buffers ARRAY_DIM rows, then shifts them bottom-row-first
// down the array psum chain. Define WLOAD_DOUBLE_BUF_EN for ping-pong staging banks.
module weight_loader
  import wload_pkg::*;
#(
  parameter int unsigned ARRAY_DIM = DEF_ARRAY_DIM,
  parameter int unsigned W_W       = DEF_W_W,
  parameter int unsigned PSUM_W    = DEF_PSUM_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [ARRAY_DIM*W_W-1:0]    s_data,
  input  logic                        array_idle,
  output logic [ARRAY_DIM*PSUM_W-1:0] psum_top,
  output logic                        en_weight_pass,
  output logic [ARRAY_DIM-1:0]        en_weight_capture,
  output logic                        load_done,
  output logic                        busy
);

  localparam int unsigned ROW_W = ARRAY_DIM * W_W;
  localparam int unsigned IDX_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int unsigned CNT_W = $clog2(ARRAY_DIM + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_DIM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ARRAY_DIM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ARRAY_DIM - 1);

  localparam logic [1:0] ST_FILL  = 2'(FILL);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT_IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]                  state;
  logic [CNT_W-1:0]            row_cnt;
  logic [IDX_W-1:0]            shift_cnt;
  logic                        accept;
  logic                        last_row;
  logic                        go_wait;
  logic [IDX_W-1:0]            wr_idx;
  logic [IDX_W-1:0]            rd_idx;
  logic [ROW_W-1:0]            rd_row;
  logic [ARRAY_DIM*PSUM_W-1:0] psum_next;

  assign accept   = s_valid & s_ready;
  assign last_row = accept && (row_cnt == LAST_CNT);
  assign wr_idx   = row_cnt[IDX_W-1:0];
  assign rd_idx   = LAST_IDX - shift_cnt;

`ifdef WLOAD_DOUBLE_BUF_EN
  logic             fill_bank;
  logic [ROW_W-1:0] rd_row0;
  logic [ROW_W-1:0] rd_row1;

  // row_cnt tracks the fill bank only, so filling continues while the other bank shifts
  assign s_ready = (row_cnt < FULL_CNT);
  assign go_wait = ((state == ST_FILL) || (state == ST_DONE)) &&
                   ((row_cnt == FULL_CNT) || last_row);

  wload_row_buf #(.DEPTH(ARRAY_DIM), .WIDTH(ROW_W), .IDX_W(IDX_W)) u_bank0 (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (accept && !fill_bank),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_row0)
  );

  wload_row_buf #(.DEPTH(ARRAY_DIM), .WIDTH(ROW_W), .IDX_W(IDX_W)) u_bank1 (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (accept && fill_bank),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_row1)
  );

  assign rd_row = fill_bank ? rd_row0 : rd_row1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_bank <= 1'b0;
    end else if (go_wait) begin
      fill_bank <= ~fill_bank;
    end
  end
`else
  assign s_ready = (state == ST_FILL) && (row_cnt < FULL_CNT);
  assign go_wait = (state == ST_FILL) && last_row;

  wload_row_buf #(.DEPTH(ARRAY_DIM), .WIDTH(ROW_W), .IDX_W(IDX_W)) u_bank0 (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (accept),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_row)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_cnt <= '0;
    end else if (go_wait) begin
      row_cnt <= '0;
    end else if (accept) begin
      row_cnt <= row_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FILL;
      shift_cnt <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (go_wait) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (array_idle) begin
            state     <= ST_SHIFT;
            shift_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (shift_cnt == LAST_IDX) state <= ST_DONE;
          else                       shift_cnt <= shift_cnt + IDX_W'(1);
        end
        ST_DONE: begin
          state <= go_wait ? ST_WAIT : ST_FILL;
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  always_comb begin
    psum_next = '0;
    if (state == ST_SHIFT) begin
      for (int unsigned c = 0; c < ARRAY_DIM; c++) begin
        psum_next[c*PSUM_W +: PSUM_W] = PSUM_W'(rd_row[c*W_W +: W_W]);
      end
    end
  end

  // Outputs are registered copies of the current-state decode, one cycle behind state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psum_top          <= '0;
      en_weight_pass    <= 1'b0;
      en_weight_capture <= '0;
      load_done         <= 1'b0;
      busy              <= 1'b0;
    end else begin
      psum_top          <= psum_next;
      en_weight_pass    <= (state == ST_SHIFT);
      en_weight_capture <= ((state == ST_SHIFT) && (shift_cnt == LAST_IDX)) ? '1 : '0;
      load_done         <= (state == ST_DONE);
      busy              <= (state != ST_FILL);
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader (default single-bank build).
module tb_weight_loader;
  import wload_pkg::*;

  localparam int unsigned N  = DEF_ARRAY_DIM;
  localparam int unsigned PW = DEF_PSUM_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s_valid;
  logic              s_ready;
  logic [N*DEF_W_W-1:0] s_data;
  logic              array_idle;
  logic [N*PW-1:0]   psum_top;
  logic              en_weight_pass;
  logic [N-1:0]      en_weight_capture;
  logic              load_done;
  logic              busy;

  typedef struct {
    logic [N*PW-1:0] psum;
    logic [N-1:0]    cap;
  } beat_t;

  beat_t      beat_q[$];
  wload_row_t w_q[$];
  wload_row_t rows_acc[$];
  wload_row_t pe_w   [N];
  logic [N*PW-1:0] pe_reg [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_edge = 0;
  int ld_edge = 0;
  bit lat_chk = 1'b1;

  weight_loader #(.ARRAY_DIM(N), .W_W(DEF_W_W), .PSUM_W(PW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .array_idle        (array_idle),
    .psum_top          (psum_top),
    .en_weight_pass    (en_weight_pass),
    .en_weight_capture (en_weight_capture),
    .load_done         (load_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic wload_row_t mk_row(input int base, input int r);
    wload_row_t v;
    for (int c = 0; c < N; c++) v[c] = 8'(base + 16*r + c);
    return v;
  endfunction

  // Scoreboard producer, PE-chain model and consumer, all sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (s_valid && s_ready) begin
        rows_acc.push_back(s_data);
        if (rows_acc.size() == N) begin
          for (int k = 0; k < N; k++) begin
            beat_t b;
            b.psum = '0;
            for (int c = 0; c < N; c++) b.psum[c*PW +: PW] = 16'(rows_acc[N-1-k][c]);
            b.cap = (k == N-1) ? '1 : '0;
            beat_q.push_back(b);
          end
          for (int r = 0; r < N; r++) w_q.push_back(rows_acc[r]);
          rows_acc.delete();
          last_hs_edge = cyc + 1;
        end
      end

      if (en_weight_pass) begin
        check("beat_avail", 64'(beat_q.size() != 0), 64'(1));
        if (beat_q.size() != 0) begin
          beat_t e;
          e = beat_q.pop_front();
          check("psum_top", psum_top, e.psum);
          check("capture", 64'(en_weight_capture), 64'(e.cap));
        end
        for (int r = N-1; r >= 0; r--) begin
          logic [N*PW-1:0] inp;
          if (r == 0) inp = psum_top;
          else        inp = pe_reg[r-1];
          if (en_weight_capture[r])
            for (int c = 0; c < N; c++) pe_w[r][c] = inp[c*PW +: 8];
          pe_reg[r] = inp;
        end
      end else begin
        check("idle_psum", psum_top, 0);
        check("idle_cap", 64'(en_weight_capture), 0);
      end

      if (load_done) begin
        ld_edge = cyc;
        check("done_avail", 64'(w_q.size() >= N), 64'(1));
        if (lat_chk) check("done_lat", 64'(cyc - last_hs_edge), 64'(6));
        if (w_q.size() >= N) begin
          for (int r = 0; r < N; r++) begin
            wload_row_t ew;
            ew = w_q.pop_front();
            check("pe_weight", 64'(pe_w[r]), 64'(ew));
          end
        end
      end
    end
  end

  task automatic send_row(input wload_row_t d, output int hs_edge);
    int n;
    n = 0;
    hs_edge = -1;
    s_data  = d;
    s_valid = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (s_ready) begin
        hs_edge = cyc + 1;
        break;
      end
    end
    if (hs_edge < 0) check("hs_timeout", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_done && n < 100);
    check("done_seen", 64'(load_done), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    int n;
    reset_n    = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    array_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready), 1);
    check("rst_pass", 64'(en_weight_pass), 0);
    check("rst_cap", 64'(en_weight_capture), 0);
    check("rst_done", 64'(load_done), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_psum", psum_top, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // basic load, 16*r+c
    for (int r = 0; r < N; r++) send_row(mk_row(0, r), hs);
    s_valid = 1'b0;
    wait_done();

    // array busy for a while after the fill
    lat_chk    = 1'b0;
    array_idle = 1'b0;
    for (int r = 0; r < N; r++) send_row(mk_row(8'h21, r), hs);
    s_valid = 1'b0;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      check("stall_busy", 64'(busy), 1);
      check("stall_pass", 64'(en_weight_pass), 0);
    end
    @(posedge clk);
    #1;
    array_idle = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume_pass0", 64'(en_weight_pass), 0);
    @(negedge clk);
    check("resume_pass1", 64'(en_weight_pass), 1);
    wait_done();
    lat_chk = 1'b1;

    // s_valid held high across a full buffer
    for (int i = 0; i < 2*N; i++) begin
      send_row(mk_row(8'h40 + 8'h40*(i/N), i % N), hs);
      if (i == N) check("fifth_row_edge", 64'(hs - ld_edge), 64'(1));
    end
    s_valid = 1'b0;
    wait_done();

    // s_valid toggling with junk data during the gaps
    for (int r = 0; r < N; r++) begin
      send_row(mk_row(8'h07, r), hs);
      s_valid = 1'b0;
      s_data  = $urandom;
      @(posedge clk);
      #1;
    end
    wait_done();

    // reset mid-SHIFT at k=2
    for (int r = 0; r < N; r++) send_row(mk_row(8'h83, r), hs);
    s_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!en_weight_pass && n < 50);
    check("shift_seen", 64'(en_weight_pass), 1);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    beat_q.delete();
    w_q.delete();
    rows_acc.delete();
    #1;
    check("arst_pass", 64'(en_weight_pass), 0);
    check("arst_cap", 64'(en_weight_capture), 0);
    check("arst_psum", psum_top, 0);
    check("arst_busy", 64'(busy), 0);
    check("arst_ready", 64'(s_ready), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) send_row(mk_row(8'hA5, r), hs);
    s_valid = 1'b0;
    wait_done();

    repeat (3) @(posedge clk);
    check("beat_q_empty", 64'(beat_q.size()), 0);
    check("w_q_empty", 64'(w_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
